synth_result_collector: RTL
===========================

SYNTH_RESULT_COLLECTOR -- requirements
Module: synth_result_collector

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the result sample.
REQ-002 The block SHALL have parameter LEN_W, default 8, meaning the width of the frame-length field.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port res_valid, input, 1 bit: res_data holds a valid sample this cycle.
REQ-006 The block SHALL have port res_data, input, DATA_W bits: registered result from the upstream compute core.
REQ-007 The block SHALL have port frame_len, input, LEN_W bits: samples per frame; value 0 means 2^LEN_W.
REQ-008 The block SHALL have port abort, input, 1 bit: discard the partial frame.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a summary is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the summary.
REQ-011 The block SHALL have port out_sum, output, DATA_W+LEN_W bits: unsigned sum of the frame samples.
REQ-012 The block SHALL have port out_xor, output, DATA_W bits: XOR of the frame samples.
REQ-013 The block SHALL have port out_max, output, DATA_W bits: unsigned maximum of the frame samples.
REQ-014 The block SHALL have port out_cnt, output, LEN_W+1 bits: number of samples in the frame.
REQ-015 The block SHALL have port busy, output, 1 bit: a frame is partially accumulated.
REQ-016 The block SHALL have port drop_cnt, output, 8 bits: saturating count of dropped summaries.
REQ-017 The block SHALL have port drop_err, output, 1 bit: sticky flag, set on the first drop.

Function
REQ-018 The block SHALL implement a state machine with states IDLE and ACCUM.
REQ-019 The block SHALL, on res_valid in IDLE, latch frame_len into len_q, set sum=zero-extended res_data, xor=res_data, max=res_data and cnt=1, then go to ACCUM.
REQ-020 The block SHALL, on res_valid in ACCUM, update: sum+=res_data, xor^=res_data, max=max(max,res_data), cnt+=1; frame_len SHALL be ignored while in ACCUM.
REQ-021 The block SHALL complete the frame in the cycle whose sample makes the effective cnt equal len_q; this also applies to the first sample when len_q=1.
REQ-022 The block SHALL, on completion, push {sum,xor,max,cnt} including that sample into the summary FIFO and go to IDLE, so that the next cycle's sample starts a new frame with no gap.
REQ-023 The block SHALL hold state and accumulators unchanged when res_valid is 0.
REQ-024 The block SHALL sum without overflow: sum width DATA_W+LEN_W covers 2^LEN_W maximal samples.
REQ-025 The summary FIFO SHALL be 2 entries deep.
REQ-026 The block SHALL drive out_valid high whenever the FIFO is non-empty and SHALL drive out_* from the head entry.
REQ-027 The block SHALL pop the FIFO when out_valid and out_ready are both high.
REQ-028 While out_valid is high and out_ready is low, the block SHALL hold out_* stable.
REQ-029 Latency: a summary SHALL appear on out_valid no earlier than the cycle after its final sample is accepted; with an empty FIFO, exactly that cycle.
REQ-030 On push with a full FIFO and a simultaneous pop, the block SHALL accept the push with no drop.
REQ-031 On push with a full FIFO and no pop, the block SHALL discard the new summary, increment drop_cnt (saturating at 255) and set drop_err.
REQ-032 On abort=1, the block SHALL clear accumulators and cnt and go to IDLE, discarding any res_data in that cycle; the FIFO, drop_cnt and drop_err SHALL be unaffected.
REQ-033 If abort and a completing sample coincide, abort SHALL take priority and nothing SHALL be pushed.
REQ-034 The block SHALL drive busy=1 exactly when in state ACCUM.

Reset
REQ-035 When rst_n=0 at a clock edge, the block SHALL go to IDLE and clear the FIFO, accumulators, len_q, drop_cnt and drop_err.
REQ-036 During reset, out_valid, busy and drop_err SHALL be 0 and out_sum, out_xor, out_max and out_cnt SHALL be 0.
REQ-037 Reset mid-frame or with the FIFO occupied SHALL discard all data, with no summary emitted.

Verification
REQ-038 Bench: frame_len=4; samples 1,2,3,0xFFFFFFFF back-to-back with out_ready=1 -> one summary the next cycle with sum=0x0100000005, xor=0xFFFFFFFF, max=0xFFFFFFFF, cnt=4.
REQ-039 Bench: frame_len=1; samples 7,9 on consecutive cycles -> two summaries: sum=7 cnt=1, then sum=9 cnt=1.
REQ-040 Bench: frame_len=2; out_ready=0; send 6 samples -> 2 summaries held, 1 dropped, drop_cnt=1, drop_err=1; then out_ready=1 -> first two frames drained in order.
REQ-041 Bench: FIFO full; completion coincides with out_ready=1 -> no drop, and occupancy stays 2.
REQ-042 Bench: frame_len=8; 3 samples, then abort, then 8 samples of value 1 -> one summary with sum=8, cnt=8.
REQ-043 Bench: frame_len=0; 256 samples of 0xFFFFFFFF -> sum=0xFFFFFFFF00, cnt=256; rst_n=0 mid-frame -> busy=0 and out_valid=0 the next cycle.

Source files
------------

// File: rtl/synth_result_collector.sv
// ---------------------------------------------------------------------------
// synth_result_collector
//
// Purpose:
//   Groups a stream of result samples into frames of frame_len samples and,
//   for each completed frame, produces a summary made of the unsigned sum,
//   the XOR and the unsigned maximum of the samples, plus the sample count.
//   Summaries are queued in a two-entry FIFO with a valid/ready handshake.
//   A summary that arrives while the FIFO is full and not being drained is
//   discarded and recorded in a saturating drop counter and a sticky flag.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   res_valid  in   res_data carries a sample this cycle
//   res_data   in   DATA_W-bit sample
//   frame_len  in   samples per frame (0 means 2^LEN_W), taken at frame start
//   abort      in   discard the partially accumulated frame
//   out_valid  out  a summary is presented
//   out_ready  in   consumer accepts the presented summary
//   out_sum    out  DATA_W+LEN_W-bit sum of the frame samples
//   out_xor    out  XOR of the frame samples
//   out_max    out  unsigned maximum of the frame samples
//   out_cnt    out  number of samples in the frame (LEN_W+1 bits)
//   busy       out  a frame is partially accumulated
//   drop_cnt   out  saturating count of discarded summaries
//   drop_err   out  sticky, set on the first discarded summary
// ---------------------------------------------------------------------------
module synth_result_collector #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    res_valid,
   input  logic [DATA_W-1:0]       res_data,
   input  logic [LEN_W-1:0]        frame_len,
   input  logic                    abort,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W+LEN_W-1:0] out_sum,
   output logic [DATA_W-1:0]       out_xor,
   output logic [DATA_W-1:0]       out_max,
   output logic [LEN_W:0]          out_cnt,
   output logic                    busy,
   output logic [7:0]              drop_cnt,
   output logic                    drop_err
);

   localparam int SUM_W = DATA_W + LEN_W;
   localparam int CNT_W = LEN_W + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   typedef struct packed {
      logic [SUM_W-1:0]  sum;
      logic [DATA_W-1:0] xr;
      logic [DATA_W-1:0] mx;
      logic [CNT_W-1:0]  cnt;
   } summary_t;

   // A length field of zero stands for a full 2^LEN_W-sample frame.
   function automatic logic [CNT_W-1:0] eff_len(input logic [LEN_W-1:0] l);
      if (l == '0) begin
         eff_len = {1'b1, {LEN_W{1'b0}}};
      end else begin
         eff_len = {1'b0, l};
      end
   endfunction

   // ------------------------------------------------------------------------
   // Frame accumulator state
   // ------------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [DATA_W-1:0]  xor_q, xor_d;
   logic [DATA_W-1:0]  max_q, max_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Values the frame would hold after taking this cycle's sample.
   logic [SUM_W-1:0]   samp_sum;
   logic [DATA_W-1:0]  samp_xor;
   logic [DATA_W-1:0]  samp_max;
   logic [CNT_W-1:0]   samp_cnt;
   logic [LEN_W-1:0]   samp_len;
   logic               samp_done;

   // Completed summary offered to the FIFO this cycle.
   logic               push;
   summary_t           push_ent;

   // ------------------------------------------------------------------------
   // Summary FIFO state
   // ------------------------------------------------------------------------
   summary_t           ent_q [2];
   summary_t           ent_d [2];
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [1:0]         count_q, count_d;
   logic [7:0]         drop_cnt_q, drop_cnt_d;
   logic               drop_err_q, drop_err_d;

   logic               fifo_full;
   logic               pop;
   logic               do_wr;
   logic               do_drop;
   summary_t           head;

   // ------------------------------------------------------------------------
   // Candidate update: in IDLE the sample opens a new frame with the length
   // presented now; in ACCUM it extends the frame using the latched length.
   // ------------------------------------------------------------------------
   always_comb begin
      samp_sum = {{LEN_W{1'b0}}, res_data};
      samp_xor = res_data;
      samp_max = res_data;
      samp_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
      samp_len = frame_len;
      if (state_q == ACCUM) begin
         samp_sum = sum_q + {{LEN_W{1'b0}}, res_data};
         samp_xor = xor_q ^ res_data;
         samp_max = (res_data > max_q) ? res_data : max_q;
         samp_cnt = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         samp_len = len_q;
      end
      samp_done = (samp_cnt == eff_len(samp_len));
   end

   // ------------------------------------------------------------------------
   // Next-state / accumulator logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      sum_d    = sum_q;
      xor_d    = xor_q;
      max_d    = max_q;
      cnt_d    = cnt_q;
      push     = 1'b0;
      push_ent = '{sum: samp_sum, xr: samp_xor, mx: samp_max, cnt: samp_cnt};

      if (abort) begin
         // Abort wins over any sample, including one that would complete.
         state_d = IDLE;
         sum_d   = '0;
         xor_d   = '0;
         max_d   = '0;
         cnt_d   = '0;
      end else if (res_valid) begin
         len_d = samp_len;
         if (samp_done) begin
            // Clearing here lets the very next sample open a fresh frame.
            push    = 1'b1;
            state_d = IDLE;
            sum_d   = '0;
            xor_d   = '0;
            max_d   = '0;
            cnt_d   = '0;
         end else begin
            state_d = ACCUM;
            sum_d   = samp_sum;
            xor_d   = samp_xor;
            max_d   = samp_max;
            cnt_d   = samp_cnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         sum_q   <= '0;
         xor_q   <= '0;
         max_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         xor_q   <= xor_d;
         max_q   <= max_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Two-entry summary FIFO. When full, a simultaneous pop frees the head
   // slot, which is the slot the write pointer already addresses, so the
   // push lands there while the old head is being consumed.
   // ------------------------------------------------------------------------
   assign head      = ent_q[rd_ptr_q];
   assign fifo_full = (count_q == 2'd2);
   assign pop       = (count_q != 2'd0) && out_ready;
   assign do_wr     = push && (!fifo_full || pop);
   assign do_drop   = push && fifo_full && !pop;

   always_comb begin
      ent_d[0]   = ent_q[0];
      ent_d[1]   = ent_q[1];
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      drop_err_d = drop_err_q;

      if (do_wr) begin
         ent_d[wr_ptr_q] = push_ent;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_wr, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      if (do_drop) begin
         drop_err_d = 1'b1;
         if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent_q[0]   <= '0;
         ent_q[1]   <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         drop_cnt_q <= 8'd0;
         drop_err_q <= 1'b0;
      end else begin
         ent_q[0]   <= ent_d[0];
         ent_q[1]   <= ent_d[1];
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
         drop_err_q <= drop_err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs. Stale slot contents are masked so the summary bus reads zero
   // whenever nothing is presented.
   // ------------------------------------------------------------------------
   assign out_valid = (count_q != 2'd0);
   assign out_sum   = out_valid ? head.sum : '0;
   assign out_xor   = out_valid ? head.xr  : '0;
   assign out_max   = out_valid ? head.mx  : '0;
   assign out_cnt   = out_valid ? head.cnt : '0;
   assign busy      = (state_q == ACCUM);
   assign drop_cnt  = drop_cnt_q;
   assign drop_err  = drop_err_q;

endmodule
